// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmit lane between two packet sources. A round-robin
//   arbiter grants one requester, latches its PACKET_SIZE-bit packet and sends
//   it MSB byte first. Each byte goes out as start(0), d0..d7 (LSB first),
//   even parity (^byte) and stop(1), one bit per clk_baud cycle. GAP_BITS
//   idle-high bit times follow every stop bit.
//
// Ports
//   clk_baud  in   bit-rate clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   req0/1    in   level requests, held until the matching grant
//   pkt0/1    in   packets, sampled only on the grant edge
//   gnt0/1    out  one-cycle pulse: packet accepted
//   tx        out  serial line, idle high
//   busy      out  high from the grant cycle until return to IDLE
//   src       out  source currently/last granted
//   done      out  one-cycle pulse in the cycle after the final stop bit
module uart_tx_scheduler #(
  parameter int PACKET_SIZE = 32,
  parameter int GAP_BITS    = 1
) (
  input  logic                   clk_baud,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [PACKET_SIZE-1:0] pkt0,
  output logic                   gnt0,
  input  logic                   req1,
  input  logic [PACKET_SIZE-1:0] pkt1,
  output logic                   gnt1,
  output logic                   tx,
  output logic                   busy,
  output logic                   src,
  output logic                   done
);

  localparam int NUM_BYTES = PACKET_SIZE / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_BITS - 1);

  if (PACKET_SIZE <= 0 || (PACKET_SIZE % 8) != 0) begin : g_bad_size
    $error("uart_tx_scheduler: PACKET_SIZE must be a nonzero multiple of 8");
  end
  if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_gap
    $error("uart_tx_scheduler: GAP_BITS must be in 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             bit_q, bit_d;
  logic [3:0]             gap_q, gap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
  logic                   prefer1_q, prefer1_d;  // 1: source 1 wins a tie
  logic                   src_q, src_d;
  logic                   tx_q, tx_d;
  logic                   gnt0_q, gnt0_d;
  logic                   gnt1_q, gnt1_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   last_byte;
  logic                   grant0, grant1;
  logic [7:0]             byte_d;

  assign last_byte = (idx_q == LAST_IDX);
  assign grant0    = req0 & (~req1 | ~prefer1_q);
  assign grant1    = req1 & (~req0 |  prefer1_q);

  // Next-state logic. The current byte is always the top byte of the store;
  // the store shifts left by a byte whenever the next byte's START begins.
  // Registered tx is derived from the *next* state so the line shows the bit
  // belonging to the state being entered.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    prefer1_d = prefer1_q;
    src_d     = src_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          shreg_d   = pkt0;
          src_d     = 1'b0;
          prefer1_d = 1'b1;
          gnt0_d    = 1'b1;
          idx_d     = '0;
          state_d   = S_START;
        end else if (grant1) begin
          shreg_d   = pkt1;
          src_d     = 1'b1;
          prefer1_d = 1'b0;
          gnt1_d    = 1'b1;
          idx_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = S_PARITY;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        done_d = last_byte;
        if (GAP_BITS != 0) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (last_byte) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shreg_d = shreg_q << 8;
          state_d = S_START;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (last_byte) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q << 8;
            state_d = S_START;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_d = shreg_d[PACKET_SIZE-1 -: 8];
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = byte_d[bit_d];
      S_PARITY: tx_d = ^byte_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      prefer1_q <= 1'b0;
      src_q     <= 1'b0;
      tx_q      <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      prefer1_q <= prefer1_d;
      src_q     <= src_d;
      tx_q      <= tx_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign src  = src_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: instance A (16-bit packets, one gap
// bit) and instance B (8-bit packets, no gap bits).
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req0_a, req1_a, gnt0_a, gnt1_a, tx_a, busy_a, src_a, done_a;
  logic [15:0] pkt0_a, pkt1_a;
  logic        rst_b, req0_b, req1_b, gnt0_b, gnt1_b, tx_b, busy_b, src_b, done_b;
  logic [7:0]  pkt0_b, pkt1_b;

  uart_tx_scheduler #(.PACKET_SIZE(16), .GAP_BITS(1)) u_dut_a (
    .clk_baud(clk), .rst(rst_a),
    .req0(req0_a), .pkt0(pkt0_a), .gnt0(gnt0_a),
    .req1(req1_a), .pkt1(pkt1_a), .gnt1(gnt1_a),
    .tx(tx_a), .busy(busy_a), .src(src_a), .done(done_a)
  );

  uart_tx_scheduler #(.PACKET_SIZE(8), .GAP_BITS(0)) u_dut_b (
    .clk_baud(clk), .rst(rst_b),
    .req0(req0_b), .pkt0(pkt0_b), .gnt0(gnt0_b),
    .req1(req1_b), .pkt1(pkt1_b), .gnt1(gnt1_b),
    .tx(tx_b), .busy(busy_b), .src(src_b), .done(done_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0;
    repeat (2) tick();
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0;
    repeat (2) tick();
    rst_b = 1'b0;
  endtask

  logic [22:0] exp23;
  logic [10:0] exp11;
  int          which, cyc;
  logic        found;
  logic [3:0]  exp_src;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req0_a = 1'b0; req1_a = 1'b0; pkt0_a = '0; pkt1_a = '0;
    req0_b = 1'b0; req1_b = 1'b0; pkt0_b = '0; pkt1_b = '0;

    // 1: reset held, no requests: {tx,busy,gnt0,gnt1,done,src} = 100000
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_idle_a", 32'({tx_a, busy_a, gnt0_a, gnt1_a, done_a, src_a}), 32'h20);
      check("rst_idle_b", 32'({tx_b, busy_b, gnt0_b, gnt1_b, done_b, src_b}), 32'h20);
    end
    rst_a = 1'b0; rst_b = 1'b0;

    // 2: A, pkt0=A53C; a req1 raised and dropped while busy must be lost
    reset_a();
    exp23 = 23'b01010010101_1_00011110001;
    req0_a = 1'b1; pkt0_a = 16'hA53C;
    tick();
    check("t2_gnt0", 32'(gnt0_a), 32'd1);
    check("t2_busy0", 32'(busy_a), 32'd1);
    check("t2_src", 32'(src_a), 32'd0);
    check("t2_tx0", 32'(tx_a), 32'(exp23[22]));
    req0_a = 1'b0;
    for (int i = 1; i < 23; i++) begin
      tick();
      if (i == 4)  req1_a = 1'b1;
      if (i == 10) req1_a = 1'b0;
      check("t2_tx", 32'(tx_a), 32'(exp23[22-i]));
      check("t2_busy", 32'(busy_a), 32'd1);
      check("t2_nopulse", 32'({gnt0_a, gnt1_a, done_a}), 32'd0);
    end
    tick();
    check("t2_done", 32'(done_a), 32'd1);
    check("t2_gap_tx", 32'(tx_a), 32'd1);
    check("t2_gap_busy", 32'(busy_a), 32'd1);
    tick();
    check("t2_idle_busy", 32'(busy_a), 32'd0);
    check("t2_idle_done", 32'(done_a), 32'd0);
    check("t2_idle_tx", 32'(tx_a), 32'd1);
    tick();
    check("t2_req1_lost", 32'({gnt1_a, busy_a}), 32'd0);

    // 6: A, pkt0 changed right after the grant; latched 8001 must go out
    reset_a();
    exp23 = 23'b00000000111_1_01000000011;
    req0_a = 1'b1; pkt0_a = 16'h8001;
    tick();
    check("t6_gnt0", 32'(gnt0_a), 32'd1);
    check("t6_tx0", 32'(tx_a), 32'(exp23[22]));
    req0_a = 1'b0; pkt0_a = 16'hFFFF;
    for (int i = 1; i < 23; i++) begin
      tick();
      check("t6_tx", 32'(tx_a), 32'(exp23[22-i]));
    end
    tick();
    check("t6_done", 32'(done_a), 32'd1);

    // 3: A, both requests held from reset: grants 0,1,0,1, 25 cycles apart
    reset_a();
    exp_src = 4'b1010;  // bit g = expected source of grant g
    req0_a = 1'b1; req1_a = 1'b1; pkt0_a = 16'h1111; pkt1_a = 16'h2222;
    for (int g = 0; g < 4; g++) begin
      cyc = 0; found = 1'b0; which = 0;
      while (!found && cyc < 60) begin
        tick();
        cyc++;
        if (gnt0_a || gnt1_a) begin
          found = 1'b1;
          which = gnt1_a ? 1 : 0;
        end
      end
      check("t3_found", 32'(found), 32'd1);
      check("t3_order", 32'(which), 32'(exp_src[g]));
      check("t3_src", 32'(src_a), 32'(exp_src[g]));
      check("t3_onehot", 32'({gnt0_a, gnt1_a} == 2'b11), 32'd0);
      check("t3_interval", 32'(cyc), (g == 0) ? 32'd1 : 32'd25);
    end
    req0_a = 1'b0; req1_a = 1'b0;

    // 4: B, pkt1=01, no gap bits: done lands in the first IDLE cycle
    reset_b();
    exp11 = 11'b01000000011;
    req1_b = 1'b1; pkt1_b = 8'h01;
    tick();
    check("t4_gnt1", 32'(gnt1_b), 32'd1);
    check("t4_src", 32'(src_b), 32'd1);
    check("t4_busy", 32'(busy_b), 32'd1);
    check("t4_tx0", 32'(tx_b), 32'(exp11[10]));
    req1_b = 1'b0;
    for (int i = 1; i < 11; i++) begin
      tick();
      check("t4_tx", 32'(tx_b), 32'(exp11[10-i]));
      check("t4_nodone", 32'(done_b), 32'd0);
    end
    tick();
    check("t4_done", 32'(done_b), 32'd1);
    check("t4_idle_busy", 32'(busy_b), 32'd0);
    check("t4_idle_tx", 32'(tx_b), 32'd1);
    tick();
    check("t4_done_off", 32'(done_b), 32'd0);

    // 5: A, reset at d3 of byte 1 (cycle 17), then a fresh grant to source 1
    reset_a();
    req0_a = 1'b1; pkt0_a = 16'hFF00;
    tick();
    req0_a = 1'b0;
    for (int i = 2; i <= 17; i++) tick();
    check("t5_pre_tx", 32'(tx_a), 32'd0);
    check("t5_pre_busy", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("t5_rst_tx", 32'(tx_a), 32'd1);
    check("t5_rst_busy", 32'(busy_a), 32'd0);
    check("t5_rst_done", 32'(done_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_quiet", 32'({tx_a, busy_a, done_a, gnt0_a, gnt1_a}), 32'h10);
    end
    exp11 = 11'b01111000001;
    req1_a = 1'b1; pkt1_a = 16'h0F00;
    tick();
    check("t5_gnt1", 32'(gnt1_a), 32'd1);
    check("t5_src", 32'(src_a), 32'd1);
    check("t5_tx0", 32'(tx_a), 32'(exp11[10]));
    req1_a = 1'b0;
    for (int i = 1; i < 11; i++) begin
      tick();
      check("t5_tx", 32'(tx_a), 32'(exp11[10-i]));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
